uart_rx_frame: RTL

Byte-level UART receiver feeding the register-assembly stage downstream. It samples the asynchronous serial line and recovers 8N1 bytes with mid-bit sampling. It issues a one-cycle strobe per good byte and a one-cycle end-of-frame strobe when the line has been idle for a programmable gap after at least one byte. Its outputs connect directly to the downstream assembler's `rx_data`, `rx_data_valid`, `rx_ack` and `rx_frame_ack` inputs.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 37 +++
 rtl/uart_rx_frame.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the 8N1 UART receive path.
// State codes are plain localparams so older tools can consume the package.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef logic [1:0] uart_state_t;

   localparam uart_state_t StIdle  = 2'd0;
   localparam uart_state_t StStart = 2'd1;
   localparam uart_state_t StData  = 2'd2;
   localparam uart_state_t StStop  = 2'd3;

   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clearable divide-by-BaudDiv counter with mid-bit and end-of-bit strobes.
module uart_baud_cnt import uart_pkg::*; #(
   parameter int unsigned BaudDiv = baud_div(50_000_000, 115200)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   output logic mid_tick_o,
   output logic bit_tick_o
);

   localparam int unsigned CntW = $clog2(BaudDiv);
   localparam logic [CntW-1:0] MidCnt  = CntW'(BaudDiv / 2 - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(BaudDiv - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      if (clr_i || (cnt_q == LastCnt)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign mid_tick_o = (cnt_q == MidCnt);
   assign bit_tick_o = (cnt_q == LastCnt);

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: mid-bit sampling, per-byte strobe, framing-error strobe
// and an end-of-frame strobe after a programmable idle gap.
module uart_rx_frame import uart_pkg::*; #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned IDLE_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_data_valid,
   output logic                 rx_ack,
   output logic                 rx_frame_ack,
   output logic                 rx_err
);

   localparam int unsigned BaudDiv = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int unsigned GapMax  = IDLE_BITS * BaudDiv;
   localparam int unsigned GapW    = $clog2(GapMax + 1);
   localparam int unsigned IdxW    = $clog2(DATA_BITS);
   localparam logic [GapW-1:0] GapLast = GapW'(GapMax - 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

   if (BaudDiv < 4) begin : g_div_check
      $error("uart_rx_frame: BAUD_DIV must be at least 4");
   end
   if ((IDLE_BITS < 1) || (IDLE_BITS > 255)) begin : g_idle_check
      $error("uart_rx_frame: IDLE_BITS must be in 1..255");
   end

   logic rxd_meta_q, rxd_sync_q, rxd_dly_q;
   logic start_edge;

   uart_state_t          state_q, state_d;
   logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ack_q, ack_d;
   logic                 err_q, err_d;
   logic                 frame_ack_q, frame_ack_d;
   logic                 pending_q, pending_d;
   logic [GapW-1:0]      gap_q, gap_d;
   logic                 cnt_clr, mid_tick, bit_tick;

   uart_baud_cnt #(
      .BaudDiv(BaudDiv)
   ) u_baud_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (cnt_clr),
      .mid_tick_o(mid_tick),
      .bit_tick_o(bit_tick)
   );

   assign start_edge = rxd_dly_q & ~rxd_sync_q;

   always_comb begin
      state_d     = state_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      frame_ack_d = 1'b0;
      pending_d   = pending_q;
      gap_d       = gap_q;
      cnt_clr     = 1'b0;

      case (state_q)
         StIdle: begin
            cnt_clr = 1'b1;
            if (start_edge) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (mid_tick) begin
               if (rxd_sync_q) begin
                  state_d = StIdle;
               end else begin
                  // Valid drops only once the start bit is confirmed, so glitches keep it.
                  state_d   = StData;
                  bit_idx_d = '0;
                  valid_d   = 1'b0;
                  cnt_clr   = 1'b1;
               end
            end
         end
         StData: begin
            if (bit_tick) begin
               shift_d   = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == LastIdx) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            if (bit_tick) begin
               state_d = StIdle;
               if (rxd_sync_q) begin
                  data_d    = shift_q;
                  valid_d   = 1'b1;
                  ack_d     = 1'b1;
                  pending_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if ((state_q != StIdle) || !rxd_sync_q || start_edge) begin
         gap_d = '0;
      end else if (pending_q) begin
         if (gap_q == GapLast) begin
            gap_d       = '0;
            frame_ack_d = 1'b1;
            pending_d   = 1'b0;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxd_meta_q  <= 1'b1;
         rxd_sync_q  <= 1'b1;
         rxd_dly_q   <= 1'b1;
         state_q     <= StIdle;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         frame_ack_q <= 1'b0;
         pending_q   <= 1'b0;
         gap_q       <= '0;
      end else begin
         rxd_meta_q  <= uart_rxd;
         rxd_sync_q  <= rxd_meta_q;
         rxd_dly_q   <= rxd_sync_q;
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         frame_ack_q <= frame_ack_d;
         pending_q   <= pending_d;
         gap_q       <= gap_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_data_valid = valid_q;
   assign rx_ack        = ack_q;
   assign rx_err        = err_q;
   assign rx_frame_ack  = frame_ack_q;

endmodule
